// File: rtl/seq_fsm.sv
// seq_fsm: N-stage pipeline sequencer with automatic/manual stages, one-cycle start
// pulses, Enter edge detection and Back navigation. Define SEQ_TIMEOUT_EN for the auto-stage timeout.
module seq_fsm #(
  parameter int                  N_STAGES       = 5,
  parameter logic [N_STAGES-1:0] AUTO_MASK      = N_STAGES'(5'b00010),
  parameter int                  BACK_MODE      = 0,
  parameter int                  TIMEOUT_CYCLES = 65_000_000,
  localparam int                 SW             = $clog2(N_STAGES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                button_enter,
  input  logic                switch,
  input  logic [N_STAGES-1:0] done,
  output logic [SW-1:0]       stage,
  output logic [N_STAGES-1:0] start,
  output logic                in_start,
  output logic                waiting_auto,
  output logic                timed_out
);

  typedef enum logic {PH_START = 1'b0, PH_WAIT = 1'b1} phase_e;

  phase_e        phase_q, phase_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [SW-1:0] stage_inc;
  logic          button_q, btn_valid_q;
  logic          press, fwd, back;
  logic          stage_valid, is_auto;
  logic          timeout_hit, set_timeout, entering;

  // The first sample after reset has no valid predecessor, so a button held
  // through reset release cannot form an edge.
  assign press = button_enter & ~button_q & btn_valid_q;
  assign fwd   = press & switch;
  assign back  = press & ~switch;

  assign stage_valid = (32'(stage_q) < 32'(N_STAGES));
  assign is_auto     = stage_valid && AUTO_MASK[stage_q];
  assign stage_inc   = (stage_q == SW'(N_STAGES - 1)) ? '0 : stage_q + 1'b1;

  // NOTE: every signal is given a default before the decision tree so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    stage_d     = stage_q;
    phase_d     = phase_q;
    set_timeout = 1'b0;
    entering    = 1'b0;
    if (!stage_valid) begin
      stage_d  = '0;
      phase_d  = PH_START;
      entering = 1'b1;
    end else if (phase_q == PH_START) begin
      phase_d = PH_WAIT;
    end else if (back && stage_q != '0) begin
      stage_d  = (BACK_MODE == 1) ? stage_q - 1'b1 : '0;
      phase_d  = PH_START;
      entering = 1'b1;
    end else if (is_auto && done[stage_q]) begin
      stage_d  = stage_inc;
      phase_d  = PH_START;
      entering = 1'b1;
    end else if (is_auto && timeout_hit) begin
      stage_d     = stage_inc;
      phase_d     = PH_START;
      entering    = 1'b1;
      set_timeout = 1'b1;
    end else if (!is_auto && fwd) begin
      stage_d  = stage_inc;
      phase_d  = PH_START;
      entering = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q     <= '0;
      phase_q     <= PH_WAIT;
      button_q    <= 1'b0;
      btn_valid_q <= 1'b0;
    end else begin
      stage_q     <= stage_d;
      phase_q     <= phase_d;
      button_q    <= button_enter;
      btn_valid_q <= 1'b1;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timed_out_q, timed_out_d;

  // cnt_q holds the WAIT cycles already spent, so the current one is cnt_q+1.
  assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (phase_q == PH_START)  cnt_d = '0;
    else if (is_auto)         cnt_d = cnt_q + 1'b1;

    timed_out_d = timed_out_q;
    if (set_timeout)                     timed_out_d = 1'b1;
    else if (entering && stage_d == '0)  timed_out_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      timed_out_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign timed_out = timed_out_q;
`else
  assign timeout_hit = 1'b0;
  assign timed_out   = 1'b0;
`endif

  always_comb begin
    start = '0;
    if (phase_q == PH_START && stage_valid) start[stage_q] = 1'b1;
  end

  assign stage        = stage_q;
  assign in_start     = (phase_q == PH_START);
  assign waiting_auto = (phase_q == PH_WAIT) && is_auto;

endmodule
